// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// default bus widths, the hard-wired zero register and the pipeline port index.
package rf_wb_arbiter_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegDataBus = 32;

    localparam logic [RegAddrBus-1:0] ZeroReg = '0;

    localparam int PIPE_PORT = 0;

endpackage

// File: rtl/rf_wb_arbiter_rr_picker.sv
// Round-robin one-hot selector: first set request at or above ptr, else lowest set.
// Ports: req (request vector), ptr (start index), gnt (one-hot grant, zero if no request).
module rf_wb_arbiter_rr_picker #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    logic [N-1:0] hi;

    always_comb begin
        // Requests at or above the pointer take precedence; isolate lowest set bit.
        hi  = req & ~((N'(1) << ptr) - N'(1));
        gnt = (|hi) ? (hi & (~hi + N'(1))) : (req & (~req + N'(1)));
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback (port 0)
// and side writers, with aging to prevent starvation; one-cycle registered output.
// Ports: req_valid/ready/waddr/wdata per requester in, rd_we/waddr/wdata/grant_id
// registered out, pipe_stall when port 0 is refused.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = RegAddrBus,
    parameter int DATA_W   = RegDataBus,
    parameter int MAX_WAIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_waddr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic                        rd_we,
    output logic [ADDR_W-1:0]           rd_waddr,
    output logic [DATA_W-1:0]           rd_wdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        pipe_stall
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    logic [ID_W-1:0]                ptr;
    logic [NUM_REQ-1:1][AGE_W-1:0]  age;
    logic [NUM_REQ-1:0]             starve;
    logic [NUM_REQ-1:0]             side;
    logic [NUM_REQ-1:0]             gnt_starve;
    logic [NUM_REQ-1:0]             gnt_side;
    logic [ID_W-1:0]                win_id;
    logic [ADDR_W-1:0]              win_addr;
    logic [DATA_W-1:0]              win_data;

    // Side-writer request sets; port 0 never enters either picker.
    always_comb begin
        starve = '0;
        side   = '0;
        for (int j = 1; j < NUM_REQ; j++) begin
            side[j]   = req_valid[j];
            starve[j] = req_valid[j] && (age[j] == AGE_MAX);
        end
    end

    rf_wb_arbiter_rr_picker #(.N(NUM_REQ)) u_pick_starve (
        .req (starve),
        .ptr (ptr),
        .gnt (gnt_starve)
    );

    rf_wb_arbiter_rr_picker #(.N(NUM_REQ)) u_pick_side (
        .req (side),
        .ptr (ptr),
        .gnt (gnt_side)
    );

    always_comb begin
        if (rst) begin
            req_ready = '0;
        end else if (|starve) begin
            req_ready = gnt_starve;
        end else if (req_valid[PIPE_PORT]) begin
            req_ready = NUM_REQ'(1) << PIPE_PORT;
        end else begin
            req_ready = gnt_side;
        end
    end

    assign pipe_stall = req_valid[PIPE_PORT] & ~req_ready[PIPE_PORT];

    // Winner mux; req_ready is one-hot or zero.
    always_comb begin
        win_id   = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                win_id   = ID_W'(i);
                win_addr = req_waddr[i*ADDR_W +: ADDR_W];
                win_data = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we    <= 1'b0;
            rd_waddr <= '0;
            rd_wdata <= '0;
            grant_id <= '0;
            ptr      <= ID_W'(1);
            age      <= '0;
        end else begin
            rd_we <= 1'b0;
            if (|req_ready) begin
                // x0 writes are consumed but never reach the regfile.
                rd_we    <= (win_addr != ADDR_W'(ZeroReg));
                rd_waddr <= win_addr;
                rd_wdata <= win_data;
                grant_id <= win_id;
                if (win_id != ID_W'(PIPE_PORT)) begin
                    ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? ID_W'(1)
                                                          : win_id + ID_W'(1);
                end
            end
            for (int j = 1; j < NUM_REQ; j++) begin
                if (!req_valid[j] || req_ready[j]) begin
                    age[j] <= '0;
                end else if (age[j] != AGE_MAX) begin
                    age[j] <= age[j] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table of per-cycle requests and
// expected grants, scoreboard of expected regfile writes, plus reset sequences.
module tb_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_waddr;
    logic [N*DW-1:0]   req_wdata;
    logic              rd_we;
    logic [AW-1:0]     rd_waddr;
    logic [DW-1:0]     rd_wdata;
    logic [1:0]        grant_id;
    logic              pipe_stall;

    rf_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_waddr  (req_waddr),
        .req_wdata  (req_wdata),
        .rd_we      (rd_we),
        .rd_waddr   (rd_waddr),
        .rd_wdata   (rd_wdata),
        .grant_id   (grant_id),
        .pipe_stall (pipe_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  er;
        logic        es;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  id;
    } wr_t;

    int checks = 0;
    int failures = 0;
    wr_t sb[$];
    logic [31:0] rf [32];
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic [1:0]  last_id = '0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] a2, input logic [31:0] d2,
                                input logic [2:0] er, input logic es);
        vec_t t;
        t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.er = er; t.es = es;
        return t;
    endfunction

    task automatic step(input vec_t t, input int n);
        wr_t w;
        @(negedge clk);
        req_valid = t.v;
        req_waddr = {t.a2, t.a1, t.a0};
        req_wdata = {t.d2, t.d1, t.d0};
        #1;
        chk($sformatf("ready[%0d]", n), 32'(req_ready), 32'(t.er));
        chk($sformatf("stall[%0d]", n), 32'(pipe_stall), 32'(t.es));
        if (t.er != 3'b000) begin
            w.id   = t.er[1] ? 2'd1 : (t.er[2] ? 2'd2 : 2'd0);
            w.addr = (w.id == 2'd0) ? t.a0 : (w.id == 2'd1) ? t.a1 : t.a2;
            w.data = (w.id == 2'd0) ? t.d0 : (w.id == 2'd1) ? t.d1 : t.d2;
            w.we   = (w.addr != 5'd0);
            sb.push_back(w);
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            w = sb.pop_front();
            last_addr = w.addr;
            last_data = w.data;
            last_id   = w.id;
            chk($sformatf("rd_we[%0d]", n), 32'(rd_we), 32'(w.we));
        end else begin
            chk($sformatf("rd_we_idle[%0d]", n), 32'(rd_we), 32'd0);
        end
        chk($sformatf("rd_waddr[%0d]", n), 32'(rd_waddr), 32'(last_addr));
        chk($sformatf("rd_wdata[%0d]", n), rd_wdata, last_data);
        chk($sformatf("grant_id[%0d]", n), 32'(grant_id), 32'(last_id));
        if (rd_we) rf[rd_waddr] = rd_wdata;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b1;
        req_valid = '0;
        req_waddr = '0;
        req_wdata = '0;

        // Idle after reset
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // Pipeline only
        tbl.push_back(mk(3'b001, 5, 32'hDEADBEEF, 0, 0, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // Round robin between ports 1 and 2
        tbl.push_back(mk(3'b110, 0, 0, 1, 32'h11, 2, 32'h22, 3'b010, 0));
        tbl.push_back(mk(3'b110, 0, 0, 1, 32'h11, 2, 32'h22, 3'b100, 0));
        tbl.push_back(mk(3'b110, 0, 0, 1, 32'h13, 2, 32'h24, 3'b010, 0));
        tbl.push_back(mk(3'b110, 0, 0, 1, 32'h13, 2, 32'h24, 3'b100, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // Starvation override of port 0
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(3'b011, 3, 32'h30 + i, 4, 32'h44, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b011, 3, 32'h40, 4, 32'h44, 0, 0, 3'b010, 1));
        tbl.push_back(mk(3'b001, 3, 32'h41, 0, 0, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // x0 write from port 2
        tbl.push_back(mk(3'b100, 0, 0, 0, 0, 0, 32'h1234, 3'b100, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        // Same register x7 back to back: port 0 then starved port 1
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(3'b011, 7, 32'h1, 7, 32'h2, 0, 0, 3'b001, 0));
        tbl.push_back(mk(3'b011, 7, 32'h1, 7, 32'h2, 0, 0, 3'b010, 1));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_we", 32'(rd_we), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_rd_waddr", 32'(rd_waddr), 32'd0);
        chk("reset_rd_wdata", rd_wdata, 32'd0);
        @(negedge clk);
        req_valid = 3'b111;
        #1;
        chk("reset_no_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
        chk("x7_final", rf[7], 32'h2);

        // Reset arriving right after a transfer drops the pending write
        @(negedge clk);
        req_valid = 3'b001;
        req_waddr = {5'd0, 5'd0, 5'd9};
        req_wdata = {32'd0, 32'd0, 32'h99};
        @(posedge clk);
        #1;
        chk("pre_rst_we", 32'(rd_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(rd_we), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_we", 32'(rd_we), 32'd0);
        chk("post_rst_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        last_addr = '0;
        last_data = '0;
        last_id   = '0;
        // Pointer back at 1 after reset
        step(mk(3'b110, 0, 0, 1, 32'h51, 2, 32'h52, 3'b010, 0), 100);
        step(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0), 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
